prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
Boot-time program loader that sits directly upstream of the single-cycle core's instruction memory. It consumes a byte stream from a serial receiver (valid/ready) and frames it as magic, length, payload and checksum. It packs the payload little-endian into 32-bit words and writes them sequentially into instruction ROM. It holds the core idle until a complete, checksum-verified image is loaded, then releases it.

Parameters:
ADDR_W, 8, instruction-memory word-address width (depth = 2**ADDR_W words)
MAGIC, 8'hA5, frame start byte

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-high reset
rx_data  input  8  received byte
rx_valid  input  1  rx_data valid this cycle
rx_ready  output  1  loader accepts a byte this cycle; transfer = rx_valid & rx_ready
rearm  input  1  single-cycle pulse; returns from DONE or ERR to IDLE
imem_we  output  1  instruction-memory write strobe, one cycle per word
imem_addr  output  ADDR_W  word address of the write
imem_wdata  output  32  word to write
core_run  output  1  high once a verified image is loaded; core held while low
done  output  1  level, high in DONE
error  output  1  level, high in ERR

Behaviour:
- Reset (async, RST=1): state=IDLE; rx_ready=0 while RST high; imem_we=0, imem_addr=0, imem_wdata=0, core_run=0, done=0, error=0; byte, word and checksum counters cleared. Memory contents are not touched.
- rx_ready=1 in IDLE, LEN_LO, LEN_HI, DATA and CSUM. rx_ready=0 in DONE and ERR. At most one byte per cycle.
- IDLE: a transfer with byte==MAGIC -> LEN_LO. Any other byte is discarded; stay in IDLE (resync).
- LEN_LO then LEN_HI: capture 16-bit word count N, little-endian.
  - After LEN_HI, if N > 2**ADDR_W -> ERR.
  - If N==0 -> CSUM.
  - Otherwise -> DATA, with word index=0 and checksum=0.
- DATA:
  - Every payload byte adds to the 8-bit checksum (modulo 256).
  - Bytes fill word lanes [7:0], [15:8], [23:16], [31:24] in order.
  - On the 4th byte's transfer cycle, the next cycle has imem_we=1, imem_wdata=the packed word and imem_addr=word index. The index then increments.
  - Write latency: 1 cycle after the 4th byte handshake. imem_we is high for exactly one cycle.
  - After word N-1 is committed -> CSUM. The final write and the CSUM entry may overlap; a byte arriving in that cycle is the checksum byte.
- CSUM: on transfer, byte==running checksum -> DONE; mismatch -> ERR.
- DONE: done=1 and core_run=1, held until rearm or RST.
- ERR: error=1 and core_run=0.
- rearm in DONE or ERR -> IDLE next cycle. core_run, done and error drop in that same transition. rearm in any other state is ignored.
- rx_valid low mid-frame: the FSM waits indefinitely; there is no timeout.
- Reset mid-frame: immediate return to IDLE. Partially written words remain in memory, and core_run stays 0.
- Address wrap cannot occur: the length check guarantees index ≤ 2**ADDR_W-1.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR)
  - MAGIC default
  - the WORD_W=32 constant shared with the core's instruction-memory interface
- One natural sub-module: prog_loader_packer. It holds the byte-lane counter, the 32-bit shift/pack register and the checksum accumulator, and emits word_valid. The FSM and address counter stay in prog_loader.

Test Plan:
- Single word: send A5, 01, 00, 13, 05, 10, 00, 28 → one imem_we pulse with addr=0 and wdata=32'h00100513; done=1, core_run=1, error=0.
- Bad checksum: same frame with final byte 29 → no extra writes beyond addr 0; error=1, core_run=0, rx_ready=0. Then rearm → IDLE with error=0.
- Resync and gaps: send 00, FF before A5; insert rx_valid=0 gaps of 3 cycles between bytes of a 3-word image → writes at addr 0, 1, 2 with correct words; leading junk ignored.
- Zero length and oversize: A5, 00, 00, 00 → done=1 with no writes. With ADDR_W=8, A5, 01, 01 (N=257) → error=1 immediately after LEN_HI.
- Back-to-back full rate: rx_valid held high for an 8-word image → exactly 8 imem_we pulses, each exactly 1 cycle after its 4th byte; addresses 0..7.
- Async reset mid-DATA: assert RST between clock edges after 2 payload bytes → all outputs 0 immediately. After release, a fresh frame loads correctly from addr 0.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot program loader: FSM encoding, frame
// start byte and the instruction-memory word width.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [7:0] MAGIC_DEF = 8'hA5;
  localparam int         WORD_W    = 32;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream receive handshake plus the instruction-memory write port.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader_packer.sv
// Packs payload bytes little-endian into 32-bit words and keeps the
// running modulo-256 checksum of every payload byte.
module prog_loader_packer
  import prog_loader_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [7:0]        data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word,
  output logic [7:0]        csum
);
  logic [1:0]  lane;
  logic [23:0] sh;

  // The 4th byte completes the word combinationally; the top registers it.
  assign word_valid = byte_en & (lane == 2'd3);
  assign word       = {data, sh};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lane <= '0;
      sh   <= '0;
      csum <= '0;
    end else if (clr) begin
      lane <= '0;
      sh   <= '0;
      csum <= '0;
    end else if (byte_en) begin
      lane <= lane + 2'd1;
      csum <= csum + data;
      case (lane)
        2'd0:    sh[7:0]   <= data;
        2'd1:    sh[15:8]  <= data;
        2'd2:    sh[23:16] <= data;
        default: sh        <= sh;
      endcase
    end
  end
endmodule

// File: rtl/prog_loader.sv
// Frames magic/length/payload/checksum from the receiver, writes words into
// instruction memory and releases the core once the image verifies.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W = 8,
  parameter logic [7:0] MAGIC  = MAGIC_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  prog_loader_if.slave  bus,
  input  logic          rearm,
  output logic          core_run,
  output logic          done,
  output logic          error
);
  localparam int DEPTH = 1 << ADDR_W;

  state_t            state, next;
  logic              accept, xfer;
  logic [7:0]        len_lo;
  logic [15:0]       len, len_in;
  logic [ADDR_W-1:0] idx;
  logic              last_word, pk_clr, pk_en, word_valid;
  logic [WORD_W-1:0] word;
  logic [7:0]        csum;

  assign accept       = state inside {IDLE, LEN_LO, LEN_HI, DATA, CSUM};
  assign bus.rx_ready = accept & ~RST;
  assign xfer         = bus.rx_valid & bus.rx_ready;
  assign len_in       = {bus.rx_data, len_lo};
  // Length capture also resets lanes, checksum and index for the new image.
  assign pk_clr       = (state == LEN_HI) & xfer;
  assign pk_en        = (state == DATA) & xfer;
  assign last_word    = (16'(idx) == len - 16'd1);

  assign done     = (state == DONE);
  assign core_run = (state == DONE);
  assign error    = (state == ERR);

  prog_loader_packer u_packer (
    .CLK        (CLK),
    .RST        (RST),
    .clr        (pk_clr),
    .byte_en    (pk_en),
    .data       (bus.rx_data),
    .word_valid (word_valid),
    .word       (word),
    .csum       (csum)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:   if (xfer && bus.rx_data == MAGIC) next = LEN_LO;
      LEN_LO: if (xfer) next = LEN_HI;
      LEN_HI: if (xfer) begin
        if (32'(len_in) > DEPTH) next = ERR;
        else if (len_in == 16'd0) next = CSUM;
        else next = DATA;
      end
      // The last word's write lands in the first CSUM cycle.
      DATA:   if (word_valid && last_word) next = CSUM;
      CSUM:   if (xfer) next = (bus.rx_data == csum) ? DONE : ERR;
      DONE:   if (rearm) next = IDLE;
      ERR:    if (rearm) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      len_lo         <= '0;
      len            <= '0;
      idx            <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else begin
      bus.imem_we <= word_valid;
      if (state == LEN_LO && xfer) len_lo <= bus.rx_data;
      if (pk_clr) begin
        len <= len_in;
        idx <= '0;
      end
      if (word_valid) begin
        bus.imem_addr  <= idx;
        bus.imem_wdata <= word;
        idx            <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench: expected writes are queued as payload is sent and
// matched (address, data, cycle) when imem_we fires.
module tb_prog_loader;
  import prog_loader_pkg::*;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic rearm = 1'b0;
  logic core_run, done, error;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   wr_cnt = 0;
  logic prev_we = 1'b0;
  exp_t exp_q[$];
  logic [31:0] words [0:15];

  prog_loader_if #(.ADDR_W(8)) bus ();

  prog_loader #(.ADDR_W(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus),
    .rearm    (rearm),
    .core_run (core_run),
    .done     (done),
    .error    (error)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST && bus.imem_we === 1'b1) begin
      wr_cnt++;
      if (prev_we) chk("we_single_cycle", 1, 0);
      if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", bus.imem_addr, e.addr);
        chk("wr_data", bus.imem_wdata, e.data);
        chk("wr_latency", cyc, e.cyc);
      end
    end
    prev_we = (bus.imem_we === 1'b1);
  end

  // Returns k = cycle count just before the handshake edge.
  task automatic send_byte(input logic [7:0] b, output int k);
    int w = 0;
    @(negedge CLK);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && w < 50) begin
      @(negedge CLK);
      w++;
    end
    k = cyc;
    if (bus.rx_ready !== 1'b1) begin
      chk("rx_ready_timeout", 0, 1);
      bus.rx_valid = 1'b0;
    end else @(posedge CLK);
  endtask

  task automatic idle(input int n);
    @(negedge CLK);
    bus.rx_valid = 1'b0;
    repeat (n - 1) @(negedge CLK);
  endtask

  task automatic send_frame(input int n, input int gap, input bit bad);
    logic [7:0]  cs = 8'h00;
    logic [7:0]  b;
    logic [15:0] nn;
    logic [31:0] w;
    int k;
    nn = 16'(n);
    send_byte(MAGIC_DEF, k);
    if (gap > 0) idle(gap);
    send_byte(nn[7:0], k);
    if (gap > 0) idle(gap);
    send_byte(nn[15:8], k);
    for (int i = 0; i < n; i++) begin
      w = words[i];
      for (int j = 0; j < 4; j++) begin
        b = w[8*j +: 8];
        cs = cs + b;
        if (gap > 0) idle(gap);
        send_byte(b, k);
        if (j == 3) exp_q.push_back('{addr: 8'(i), data: w, cyc: k + 1});
      end
    end
    if (gap > 0) idle(gap);
    send_byte(bad ? cs + 8'h01 : cs, k);
    idle(2);
  endtask

  task automatic do_rearm();
    @(negedge CLK);
    rearm = 1'b1;
    @(negedge CLK);
    rearm = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int base;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    #1 RST = 1'b1;
    #2;
    chk("rst_rx_ready", bus.rx_ready, 0);
    chk("rst_imem_we", bus.imem_we, 0);
    chk("rst_imem_addr", bus.imem_addr, 0);
    chk("rst_imem_wdata", bus.imem_wdata, 0);
    chk("rst_core_run", core_run, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("idle_rx_ready", bus.rx_ready, 1);

    // Single word, good checksum (0x13+0x05+0x10+0x00 = 0x28)
    words[0] = 32'h00100513;
    base = wr_cnt;
    send_frame(1, 0, 1'b0);
    chk("single_done", done, 1);
    chk("single_core_run", core_run, 1);
    chk("single_error", error, 0);
    chk("single_writes", wr_cnt - base, 1);
    chk("done_rx_ready", bus.rx_ready, 0);
    do_rearm();
    chk("rearm_done", done, 0);
    chk("rearm_core_run", core_run, 0);

    // Bad checksum
    base = wr_cnt;
    send_frame(1, 0, 1'b1);
    chk("bad_error", error, 1);
    chk("bad_core_run", core_run, 0);
    chk("bad_rx_ready", bus.rx_ready, 0);
    chk("bad_writes", wr_cnt - base, 1);
    do_rearm();
    chk("bad_rearm_error", error, 0);
    chk("bad_rearm_rx_ready", bus.rx_ready, 1);

    // Leading junk and 3-cycle gaps, 3 words
    words[0] = 32'hDEADBEEF;
    words[1] = 32'h01234567;
    words[2] = 32'hFF00A55A;
    base = wr_cnt;
    send_byte(8'h00, k);
    send_byte(8'hFF, k);
    send_frame(3, 3, 1'b0);
    chk("gap_done", done, 1);
    chk("gap_writes", wr_cnt - base, 3);
    do_rearm();

    // Zero length
    base = wr_cnt;
    send_frame(0, 0, 1'b0);
    chk("zero_done", done, 1);
    chk("zero_writes", wr_cnt - base, 0);
    do_rearm();

    // Oversize N=257 errors straight after LEN_HI
    send_byte(MAGIC_DEF, k);
    send_byte(8'h01, k);
    send_byte(8'h01, k);
    @(negedge CLK);
    bus.rx_valid = 1'b0;
    chk("oversize_error", error, 1);
    chk("oversize_core_run", core_run, 0);
    do_rearm();

    // Back-to-back 8 words at full rate
    for (int i = 0; i < 8; i++) words[i] = $urandom;
    base = wr_cnt;
    send_frame(8, 0, 1'b0);
    chk("b2b_done", done, 1);
    chk("b2b_writes", wr_cnt - base, 8);
    do_rearm();

    // Async reset in the middle of DATA
    send_byte(MAGIC_DEF, k);
    send_byte(8'h02, k);
    send_byte(8'h00, k);
    send_byte(8'h11, k);
    send_byte(8'h22, k);
    #2 RST = 1'b1;
    bus.rx_valid = 1'b0;
    #1;
    chk("mid_rst_rx_ready", bus.rx_ready, 0);
    chk("mid_rst_imem_we", bus.imem_we, 0);
    chk("mid_rst_imem_wdata", bus.imem_wdata, 0);
    chk("mid_rst_imem_addr", bus.imem_addr, 0);
    chk("mid_rst_core_run", core_run, 0);
    @(negedge CLK);
    RST = 1'b0;
    words[0] = 32'hCAFEF00D;
    base = wr_cnt;
    send_frame(1, 0, 1'b0);
    chk("post_rst_done", done, 1);
    chk("post_rst_writes", wr_cnt - base, 1);

    repeat (3) @(negedge CLK);
    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
